// File: rtl/game_state_controller_if.sv
// Game-state bus between the scan/button front end and the main game FSM.
// The master drives the per-pixel, tick and button inputs; the slave returns the game state.
interface game_state_controller_if #(
   parameter int CNT_W = 16
);
   logic             frame_tick;
   logic             pix_valid;
   logic             dino_px;
   logic             obs_px;
   logic             jump;
   logic             restart;
   logic [1:0]       game_state;
   logic             run_en;
   logic             death_pulse;
   logic [CNT_W-1:0] frames_alive;

   modport master (
      output frame_tick, pix_valid, dino_px, obs_px, jump, restart,
      input  game_state, run_en, death_pulse, frames_alive
   );

   modport slave (
      input  frame_tick, pix_valid, dino_px, obs_px, jump, restart,
      output game_state, run_en, death_pulse, frames_alive
   );
endinterface

// File: rtl/game_state_controller.sv
// Main game FSM: IDLE/RUN/DEAD, per-frame collision accumulation,
// restart cooldown and a saturating frames-alive counter.
module game_state_controller #(
   parameter int HIT_FRAMES     = 2,
   parameter int RESTART_FRAMES = 30,
   parameter int CNT_W          = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   game_state_controller_if.slave gameBus
);
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DEAD = 2'b10
   } state_t;

   localparam logic [3:0]       HIT_N   = 4'(HIT_FRAMES);
   localparam logic [7:0]       COOL_N  = 8'(RESTART_FRAMES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, nextState;
   logic             jumpQ, restartQ;
   logic             hitAcc, hitAccNext;
   logic [3:0]       hitCnt, hitCntNext, hitInc;
   logic [7:0]       cooldown, cooldownNext;
   logic [CNT_W-1:0] framesAlive, framesAliveNext;
   logic             deathPulse, deathNext;
   logic             runEn;
   logic             jumpRise, restartRise;
   logic             overlap, hitNow, deathCond, stateChange;

   assign jumpRise    = gameBus.jump & ~jumpQ;
   assign restartRise = gameBus.restart & ~restartQ;
   assign overlap     = (state == RUN) & gameBus.pix_valid
                      & gameBus.dino_px & gameBus.obs_px;
   assign hitNow      = hitAcc | overlap;
   assign hitInc      = hitCnt + 4'd1;
   assign deathCond   = (state == RUN) & gameBus.frame_tick
                      & hitNow & (hitInc == HIT_N);
   assign stateChange = (nextState != state);

   // Next-state selection; restart has priority over everything
   always_comb begin
      nextState = state;
      if (restartRise) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE:    if (jumpRise) nextState = RUN;
            RUN:     if (deathCond) nextState = DEAD;
            DEAD:    if (jumpRise && cooldown == 8'd0) nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   // Hit accumulation, cooldown and frames-alive next values
   always_comb begin
      hitAccNext      = hitAcc;
      hitCntNext      = hitCnt;
      cooldownNext    = cooldown;
      framesAliveNext = framesAlive;
      deathNext       = 1'b0;

      if (stateChange || gameBus.frame_tick) begin
         hitAccNext = 1'b0;
      end else if (overlap) begin
         hitAccNext = 1'b1;
      end

      if (restartRise) begin
         hitCntNext   = 4'd0;
         cooldownNext = 8'd0;
      end else if (deathCond) begin
         hitCntNext   = 4'd0;
         cooldownNext = COOL_N;
         deathNext    = 1'b1;
      end else begin
         if (stateChange) begin
            hitCntNext = 4'd0;
         end else if (state == RUN && gameBus.frame_tick) begin
            hitCntNext = hitNow ? hitInc : 4'd0;
         end
         if (state == DEAD && gameBus.frame_tick && cooldown != 8'd0) begin
            cooldownNext = cooldown - 8'd1;
         end
      end

      if (state == IDLE && nextState == RUN) begin
         framesAliveNext = '0;
      end else if (state == RUN && nextState == RUN
                   && gameBus.frame_tick && framesAlive != CNT_MAX) begin
         framesAliveNext = framesAlive + 1'b1;
      end
   end

   // State and datapath registers; buttons reset high so a held button is not an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         runEn       <= 1'b0;
         deathPulse  <= 1'b0;
         framesAlive <= '0;
         hitAcc      <= 1'b0;
         hitCnt      <= 4'd0;
         cooldown    <= 8'd0;
         jumpQ       <= 1'b1;
         restartQ    <= 1'b1;
      end else begin
         state       <= nextState;
         runEn       <= (nextState == RUN);
         deathPulse  <= deathNext;
         framesAlive <= framesAliveNext;
         hitAcc      <= hitAccNext;
         hitCnt      <= hitCntNext;
         cooldown    <= cooldownNext;
         jumpQ       <= gameBus.jump;
         restartQ    <= gameBus.restart;
      end
   end

   assign gameBus.game_state   = state;
   assign gameBus.run_en       = runEn;
   assign gameBus.death_pulse  = deathPulse;
   assign gameBus.frames_alive = framesAlive;
endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: vector table through a scoreboard queue,
// plus hand sequences for async reset and counter saturation.
module tb_game_state_controller;
   typedef struct {
      logic        ft, pv, dp, op, j, r;
      logic [1:0]  es;
      logic        ed;
      logic [15:0] fa;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   vecNo = 0;
   vec_t vecs[$];
   vec_t sb[$];

   game_state_controller_if #(.CNT_W(16)) gif ();
   game_state_controller_if #(.CNT_W(4))  sif ();

   game_state_controller #(
      .HIT_FRAMES(2), .RESTART_FRAMES(30), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .gameBus(gif.slave)
   );

   game_state_controller #(
      .HIT_FRAMES(2), .RESTART_FRAMES(30), .CNT_W(4)
   ) dutSat (
      .clk(clk), .rst_n(rst_n), .gameBus(sif.slave)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic ft, pv, dp, op, j, r,
      input logic [1:0] es, input logic ed, input int fa
   );
      vec_t v;
      v.ft = ft; v.pv = pv; v.dp = dp; v.op = op;
      v.j = j; v.r = r; v.es = es; v.ed = ed;
      v.fa = 16'(fa);
      return v;
   endfunction

   task automatic cmp(input string nm, input int idx,
                      input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      vec_t e;
      @(negedge clk);
      gif.frame_tick = v.ft;
      gif.pix_valid  = v.pv;
      gif.dino_px    = v.dp;
      gif.obs_px     = v.op;
      gif.jump       = v.j;
      gif.restart    = v.r;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp("state", vecNo, 16'(gif.game_state), 16'(e.es));
      cmp("run_en", vecNo, 16'(gif.run_en), 16'(e.es == 2'b01));
      cmp("death", vecNo, 16'(gif.death_pulse), 16'(e.ed));
      cmp("alive", vecNo, gif.frames_alive, e.fa);
      vecNo++;
   endtask

   initial begin
      gif.frame_tick = 0; gif.pix_valid = 0; gif.dino_px = 0;
      gif.obs_px = 0; gif.jump = 1; gif.restart = 0;
      sif.frame_tick = 0; sif.pix_valid = 0; sif.dino_px = 0;
      sif.obs_px = 0; sif.jump = 0; sif.restart = 0;

      // jump held through reset, then released and pressed again
      vecs.push_back(mk(0,0,0,0,1,0, 2'd0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0, 2'd0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0, 2'd1,0,0));
      vecs.push_back(mk(0,0,0,0,1,0, 2'd1,0,0));
      vecs.push_back(mk(0,0,0,0,1,0, 2'd1,0,0));
      // five frame ticks
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,1));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,2));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd1,0,2));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,3));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,4));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,5));
      // overlap with pix_valid low in two frames: ignored
      vecs.push_back(mk(0,0,1,1,0,0, 2'd1,0,5));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,6));
      vecs.push_back(mk(0,0,1,1,0,0, 2'd1,0,6));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,7));
      // hit in frame N, clean frame, hit again: no death
      vecs.push_back(mk(0,1,1,1,0,0, 2'd1,0,7));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,8));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,9));
      vecs.push_back(mk(0,1,1,1,0,0, 2'd1,0,9));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,10));
      // same-cycle overlap on the next tick: death
      vecs.push_back(mk(1,1,1,1,0,0, 2'd2,1,10));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd2,0,10));
      // cooldown: overlap in DEAD ignored, 10 ticks then jump
      vecs.push_back(mk(1,1,1,1,0,0, 2'd2,0,10));
      for (int i = 0; i < 9; i++)
         vecs.push_back(mk(1,0,0,0,0,0, 2'd2,0,10));
      vecs.push_back(mk(0,0,0,0,1,0, 2'd2,0,10));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd2,0,10));
      for (int i = 0; i < 19; i++)
         vecs.push_back(mk(1,0,0,0,0,0, 2'd2,0,10));
      vecs.push_back(mk(0,0,0,0,1,0, 2'd2,0,10));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd2,0,10));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd2,0,10));
      vecs.push_back(mk(0,0,0,0,1,0, 2'd0,0,10));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd0,0,10));
      // start with a coincident tick: tick not counted, counter cleared
      vecs.push_back(mk(1,0,0,0,1,0, 2'd1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd1,0,0));
      // restart coincident with the killing tick
      vecs.push_back(mk(0,1,1,1,0,0, 2'd1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,1));
      vecs.push_back(mk(1,1,1,1,0,1, 2'd0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0, 2'd0,0,1));
      // hit count was cleared: one hit frame must not kill
      vecs.push_back(mk(0,0,0,0,1,0, 2'd1,0,0));
      vecs.push_back(mk(1,1,1,1,1,0, 2'd1,0,1));
      vecs.push_back(mk(1,0,0,0,0,0, 2'd1,0,2));

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_state", 0, 16'(gif.game_state), 16'd0);
      cmp("rst_run", 0, 16'(gif.run_en), 16'd0);
      cmp("rst_death", 0, 16'(gif.death_pulse), 16'd0);
      cmp("rst_alive", 0, gif.frames_alive, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) drive(vecs[i]);

      // async reset mid-RUN takes effect without a clock edge
      @(negedge clk);
      gif.frame_tick = 0; gif.pix_valid = 0;
      gif.dino_px = 0; gif.obs_px = 0; gif.jump = 0;
      #2 rst_n = 1'b0;
      #1;
      cmp("arst_state", 0, 16'(gif.game_state), 16'd0);
      cmp("arst_run", 0, 16'(gif.run_en), 16'd0);
      cmp("arst_death", 0, 16'(gif.death_pulse), 16'd0);
      cmp("arst_alive", 0, gif.frames_alive, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // saturation on the narrow-counter instance
      @(negedge clk);
      sif.jump = 1;
      @(posedge clk);
      #1;
      cmp("sat_state", 0, 16'(sif.game_state), 16'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         sif.frame_tick = 1;
         @(posedge clk);
         #1;
         cmp("sat_alive", i, 16'(sif.frames_alive),
             16'((i + 1 > 15) ? 15 : i + 1));
      end
      @(negedge clk);
      sif.frame_tick = 0;
      cmp("sat_run", 0, 16'(sif.run_en), 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Main game FSM that drives the 2-bit game state consumed by the obstacle, horizon and score stages: IDLE (00), RUN (01), DEAD (10).
- Detects dino/obstacle collision from the per-pixel in-sprite flags generated during the VGA scan, accumulated once per frame.
- Handles start-on-jump, restart after death with a cooldown, and a saturating frames-alive counter for the score stage.
- Sits between the sprite delegates (upstream of collision flags) and every consumer of game state.

Parameters:
- HIT_FRAMES, 2, consecutive frames with overlap required to declare death (1..15).
- RESTART_FRAMES, 30, frame ticks in DEAD before jump may restart (0..255).
- CNT_W, 16, width of frames_alive.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-clk pulse at start of vertical blank (already synchronised to clk)
- pix_valid  in  1  current scan pixel is in the visible area
- dino_px  in  1  current pixel belongs to dino sprite
- obs_px  in  1  current pixel belongs to any obstacle sprite
- jump  in  1  debounced jump button level
- restart  in  1  debounced reset button level
- game_state  out  2  00 IDLE, 01 RUN, 10 DEAD (11 never driven)
- run_en  out  1  high iff game_state==RUN
- death_pulse  out  1  one-clk pulse on RUN->DEAD
- frames_alive  out  CNT_W  frame ticks spent in current/last run

Behaviour:
- Reset (async, rst_n low): game_state=IDLE, run_en=0, death_pulse=0, frames_alive=0, hit_acc=0, hit_cnt=0, cooldown=0, jump_q=1, restart_q=1 (a button held through reset must not trigger).
- Edge detect: jump_rise = jump & ~jump_q; restart_rise likewise; registered every clk.
- hit_acc: set on any clk with state RUN & pix_valid & dino_px & obs_px; cleared on every frame_tick and on any state change.
- Frame evaluation on frame_tick in RUN: hit_now = hit_acc | (same-cycle overlap). If hit_now, hit_cnt+1, else hit_cnt=0. When the incremented value reaches HIT_FRAMES: next state DEAD, death_pulse=1 next cycle, hit_cnt=0, cooldown=RESTART_FRAMES.
- frames_alive: +1 on each frame_tick in RUN that does not cause death; saturates at all-ones; cleared on IDLE->RUN; held in DEAD and IDLE.
- Transitions (priority top-down):
  - Any state, restart_rise: go IDLE. Clears hit_cnt and cooldown; frames_alive held.
  - IDLE, jump_rise: go RUN. A frame_tick in the same cycle is not counted.
  - RUN, death condition: go DEAD.
  - DEAD: cooldown decrements on each frame_tick while >0. jump_rise with cooldown==0 goes IDLE. jump_rise with cooldown>0 is ignored.
- restart_rise in the same cycle as a death condition: IDLE wins, no death_pulse.
- Latency: state updates one clk after the qualifying edge or tick. run_en and game_state are registered and change together.
- Overlap with pix_valid low is ignored. Overlap outside RUN is ignored.

Test Plan:
- Reset then jump high for 3 clk -> game_state 00->01 one clk after first jump clk; frames_alive=0; five frame_ticks -> frames_alive=5.
- In RUN, one clk of pix_valid&dino_px&obs_px in frame N only, HIT_FRAMES=2 -> no death; overlap in frames N and N+1 -> death_pulse exactly one clk after tick N+1, game_state=10, frames_alive frozen.
- In DEAD with RESTART_FRAMES=30: jump_rise after 10 ticks -> stays 10; after 30 ticks jump_rise -> 00; second jump_rise -> 01 with frames_alive cleared.
- Overlap in frame N followed by a clean frame, then overlap again -> hit_cnt reset to 0, no death.
- restart_rise coincident with second-frame death tick -> game_state=00, death_pulse never asserted.
- Jump held through rst_n release -> stays IDLE until jump falls and rises again; force frames_alive near 16'hFFFF -> saturates, no wrap. rst_n low mid-RUN -> immediate IDLE and all outputs 0.
